// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: MEM-unit enqueue, ROB commit/flush, data-memory write port,
// load forwarding lookup and occupancy status.
interface store_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 5
);
    logic                  enq_valid;
    logic                  enq_ready;
    logic [ADDR_WIDTH-1:0] enq_addr;
    logic [DATA_WIDTH-1:0] enq_data;
    logic [2:0]            enq_funct3;
    logic [ROB_WIDTH-1:0]  enq_rob_id;
    logic                  enq_misaligned;

    logic                  commit_valid;
    logic [ROB_WIDTH-1:0]  commit_rob_id;
    logic                  flush;

    logic                  mem_wvalid;
    logic                  mem_wready;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;

    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [2:0]            ld_funct3;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_conflict;

    logic                  empty;
    logic                  full;

    modport slave (
        input  enq_valid, enq_addr, enq_data, enq_funct3, enq_rob_id,
        input  commit_valid, commit_rob_id, flush,
        input  mem_wready, ld_addr, ld_funct3,
        output enq_ready, enq_misaligned,
        output mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
        output fwd_hit, fwd_data, fwd_conflict, empty, full
    );

    modport master (
        output enq_valid, enq_addr, enq_data, enq_funct3, enq_rob_id,
        output commit_valid, commit_rob_id, flush,
        output mem_wready, ld_addr, ld_funct3,
        input  enq_ready, enq_misaligned,
        input  mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
        input  fwd_hit, fwd_data, fwd_conflict, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: aligns stores, holds them until ROB commit, drains committed
// entries to data memory and forwards buffered data to younger loads.
module store_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 5,
    parameter int DEPTH      = 8
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_WIDTH - 2;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      cmt_q, cmt_d;
    logic [WA_W-1:0]       addr_q [DEPTH];
    logic [WA_W-1:0]       addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [3:0]            strb_q [DEPTH];
    logic [3:0]            strb_d [DEPTH];
    logic [ROB_WIDTH-1:0]  rob_q  [DEPTH];
    logic [ROB_WIDTH-1:0]  rob_d  [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  misaligned_q, misaligned_d;

    logic                  full_w;
    logic                  head_live;
    logic                  drain;
    logic                  enq_fire;
    logic                  enq_write;
    logic [1:0]            enq_off;
    logic                  enq_ok;
    logic [DATA_WIDTH-1:0] enq_wdata;
    logic [3:0]            enq_strb;
    logic [CNT_W-1:0]      n_cmt;

    assign full_w    = (count_q == CNT_W'(DEPTH));
    assign head_live = valid_q[head_q] && cmt_q[head_q];
    assign drain     = head_live && sb.mem_wready;
    assign enq_fire  = sb.enq_valid && !full_w;
    assign enq_write = enq_fire && enq_ok && !sb.flush;

    always_comb begin
        enq_off   = sb.enq_addr[1:0];
        enq_ok    = 1'b0;
        enq_wdata = '0;
        enq_strb  = '0;
        case (sb.enq_funct3)
            3'b000: begin
                enq_ok    = 1'b1;
                enq_wdata = DATA_WIDTH'(sb.enq_data[7:0]) << {enq_off, 3'b000};
                enq_strb  = 4'b0001 << enq_off;
            end
            3'b001: begin
                enq_ok    = !enq_off[0];
                enq_wdata = DATA_WIDTH'(sb.enq_data[15:0]) << {enq_off, 3'b000};
                enq_strb  = 4'b0011 << enq_off;
            end
            3'b010: begin
                enq_ok    = (enq_off == 2'b00);
                enq_wdata = sb.enq_data;
                enq_strb  = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        cmt_d        = cmt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        rob_d        = rob_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        n_cmt        = '0;
        misaligned_d = enq_fire && !enq_ok;

        // Only uncommitted entries can match, so a reused ROB tag never re-commits an old store.
        if (sb.commit_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && !cmt_q[i] && rob_q[i] == sb.commit_rob_id)
                    cmt_d[i] = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i] && cmt_d[i])
                n_cmt = n_cmt + CNT_W'(1);
        end

        if (drain) begin
            valid_d[head_q] = 1'b0;
            cmt_d[head_q]   = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        if (sb.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!cmt_d[i])
                    valid_d[i] = 1'b0;
            end
            // Committed entries are a contiguous prefix from head, including one draining now.
            tail_d  = head_q + PTR_W'(n_cmt);
            count_d = n_cmt - CNT_W'(drain);
        end else begin
            if (enq_write) begin
                valid_d[tail_q] = 1'b1;
                cmt_d[tail_q]   = 1'b0;
                addr_d[tail_q]  = sb.enq_addr[ADDR_WIDTH-1:2];
                data_d[tail_q]  = enq_wdata;
                strb_d[tail_q]  = enq_strb;
                rob_d[tail_q]   = sb.enq_rob_id;
                tail_d          = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq_write) - CNT_W'(drain);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            cmt_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            misaligned_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
                rob_q[i]  <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            cmt_q        <= cmt_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            rob_q        <= rob_d;
        end
    end

    logic [1:0]            ld_off;
    logic [3:0]            ld_mask;
    logic [PTR_W-1:0]      fwd_idx;
    logic                  fwd_found;
    logic [3:0]            fwd_strb;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  fwd_full;

    // Walk oldest to youngest so the last overlapping entry seen is the youngest.
    always_comb begin
        ld_off    = sb.ld_addr[1:0];
        fwd_idx   = '0;
        fwd_found = 1'b0;
        fwd_strb  = '0;
        fwd_word  = '0;
        case (sb.ld_funct3[1:0])
            2'b00:   ld_mask = 4'b0001 << ld_off;
            2'b01:   ld_mask = 4'b0011 << ld_off;
            default: ld_mask = 4'b1111;
        endcase
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (valid_q[fwd_idx] && addr_q[fwd_idx] == sb.ld_addr[ADDR_WIDTH-1:2]
                && (strb_q[fwd_idx] & ld_mask) != 4'b0000) begin
                fwd_found = 1'b1;
                fwd_strb  = strb_q[fwd_idx];
                fwd_word  = data_q[fwd_idx];
            end
        end
        fwd_full = ((fwd_strb & ld_mask) == ld_mask);
    end

    assign sb.fwd_hit        = fwd_found && fwd_full;
    assign sb.fwd_conflict   = fwd_found && !fwd_full;
    assign sb.fwd_data       = (fwd_found && fwd_full) ? fwd_word : '0;

    assign sb.enq_ready      = !full_w;
    assign sb.enq_misaligned = misaligned_q;
    assign sb.full           = full_w;
    assign sb.empty          = (count_q == '0);
    assign sb.mem_wvalid     = head_live;
    assign sb.mem_waddr      = head_live ? {addr_q[head_q], 2'b00} : '0;
    assign sb.mem_wdata      = head_live ? data_q[head_q] : '0;
    assign sb.mem_wstrb      = head_live ? strb_q[head_q] : '0;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: table-driven alignment vectors plus hand-written
// sequences for fill/drain, flush, forwarding, misalignment and async reset.
module tb_store_buffer;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    store_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROB_WIDTH(5)) sbi ();

    store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROB_WIDTH(5), .DEPTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_mis;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rob);
        sbi.enq_valid  = 1'b1;
        sbi.enq_funct3 = f3;
        sbi.enq_addr   = a;
        sbi.enq_data   = d;
        sbi.enq_rob_id = rob;
        step();
        sbi.enq_valid  = 1'b0;
    endtask

    task automatic commit(input logic [4:0] rob);
        sbi.commit_valid  = 1'b1;
        sbi.commit_rob_id = rob;
        step();
        sbi.commit_valid  = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a);
        sbi.ld_funct3 = f3;
        sbi.ld_addr   = a;
        #1;
    endtask

    initial begin
        vecs[0] = '{3'b000, 32'h1003, 32'hAABBCCDD, 1'b0, 32'h1000, 32'hDD000000, 4'b1000};
        vecs[1] = '{3'b000, 32'h1001, 32'hAABBCCDD, 1'b0, 32'h1000, 32'h0000DD00, 4'b0010};
        vecs[2] = '{3'b001, 32'h1002, 32'hAABBCCDD, 1'b0, 32'h1000, 32'hCCDD0000, 4'b1100};
        vecs[3] = '{3'b001, 32'h1000, 32'hAABBCCDD, 1'b0, 32'h1000, 32'h0000CCDD, 4'b0011};
        vecs[4] = '{3'b010, 32'h1004, 32'hAABBCCDD, 1'b0, 32'h1004, 32'hAABBCCDD, 4'b1111};
        vecs[5] = '{3'b001, 32'h3001, 32'h12345678, 1'b1, 32'h0,    32'h0,        4'b0000};
        vecs[6] = '{3'b010, 32'h1002, 32'h12345678, 1'b1, 32'h0,    32'h0,        4'b0000};
        vecs[7] = '{3'b011, 32'h1000, 32'h12345678, 1'b1, 32'h0,    32'h0,        4'b0000};

        rst_n = 1'b0;
        sbi.enq_valid = 1'b0; sbi.enq_addr = '0; sbi.enq_data = '0;
        sbi.enq_funct3 = '0;  sbi.enq_rob_id = '0;
        sbi.commit_valid = 1'b0; sbi.commit_rob_id = '0; sbi.flush = 1'b0;
        sbi.mem_wready = 1'b0; sbi.ld_addr = '0; sbi.ld_funct3 = '0;
        #1;
        chk("rst_wvalid", 32'(sbi.mem_wvalid), 0);
        chk("rst_empty", 32'(sbi.empty), 1);
        chk("rst_full", 32'(sbi.full), 0);
        chk("rst_enq_ready", 32'(sbi.enq_ready), 1);
        chk("rst_misaligned", 32'(sbi.enq_misaligned), 0);
        chk("rst_fwd", {30'd0, sbi.fwd_hit, sbi.fwd_conflict}, 0);
        step();
        rst_n = 1'b1;
        step();

        // Alignment table
        for (int i = 0; i < 8; i++) begin
            enq(vecs[i].funct3, vecs[i].addr, vecs[i].data, 5'(i));
            chk($sformatf("v%0d_mis", i), 32'(sbi.enq_misaligned), 32'(vecs[i].exp_mis));
            step();
            chk($sformatf("v%0d_mis_pulse", i), 32'(sbi.enq_misaligned), 0);
            chk($sformatf("v%0d_empty", i), 32'(sbi.empty), 32'(vecs[i].exp_mis));
            if (!vecs[i].exp_mis) begin
                chk($sformatf("v%0d_wvalid_precommit", i), 32'(sbi.mem_wvalid), 0);
                commit(5'(i));
                chk($sformatf("v%0d_wvalid", i), 32'(sbi.mem_wvalid), 1);
                chk($sformatf("v%0d_waddr", i), sbi.mem_waddr, vecs[i].exp_waddr);
                chk($sformatf("v%0d_wdata", i), sbi.mem_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d_wstrb", i), 32'(sbi.mem_wstrb), 32'(vecs[i].exp_wstrb));
                sbi.mem_wready = 1'b1;
                step();
                sbi.mem_wready = 1'b0;
                chk($sformatf("v%0d_drained", i), 32'(sbi.empty), 1);
            end
        end

        // Fill to full, try a 9th, commit all, drain back to back
        for (int i = 0; i < 8; i++)
            enq(3'b010, 32'h4000 + 32'(4 * i), 32'h100 + 32'(i), 5'(i));
        chk("fill_full", 32'(sbi.full), 1);
        chk("fill_enq_ready", 32'(sbi.enq_ready), 0);
        enq(3'b010, 32'h5000, 32'hDEADBEEF, 5'd8);
        chk("fill_full_after9", 32'(sbi.full), 1);
        for (int i = 0; i < 8; i++)
            commit(5'(i));
        sbi.mem_wready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_wvalid", k), 32'(sbi.mem_wvalid), 1);
            chk($sformatf("drain%0d_waddr", k), sbi.mem_waddr, 32'h4000 + 32'(4 * k));
            chk($sformatf("drain%0d_wdata", k), sbi.mem_wdata, 32'h100 + 32'(k));
            step();
        end
        sbi.mem_wready = 1'b0;
        chk("drain_empty", 32'(sbi.empty), 1);
        chk("drain_wvalid_off", 32'(sbi.mem_wvalid), 0);

        // Flush with same-cycle commit and enqueue
        for (int i = 0; i < 4; i++)
            enq(3'b010, 32'h6000 + 32'(4 * i), 32'h600 + 32'(i), 5'(10 + i));
        commit(5'd10);
        sbi.commit_valid = 1'b1; sbi.commit_rob_id = 5'd11; sbi.flush = 1'b1;
        sbi.enq_valid = 1'b1; sbi.enq_funct3 = 3'b010; sbi.enq_addr = 32'h6100;
        sbi.enq_data = 32'hBAD0BAD0; sbi.enq_rob_id = 5'd14;
        step();
        sbi.commit_valid = 1'b0; sbi.flush = 1'b0; sbi.enq_valid = 1'b0;
        chk("flush_not_empty", 32'(sbi.empty), 0);
        load(3'b010, 32'h6100);
        chk("flush_dropped_enq_fwd", 32'(sbi.fwd_hit), 0);
        sbi.mem_wready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("flush_drain%0d_wvalid", k), 32'(sbi.mem_wvalid), 1);
            chk($sformatf("flush_drain%0d_waddr", k), sbi.mem_waddr, 32'h6000 + 32'(4 * k));
            step();
        end
        sbi.mem_wready = 1'b0;
        chk("flush_only2", 32'(sbi.mem_wvalid), 0);
        chk("flush_empty", 32'(sbi.empty), 1);

        // Forwarding
        enq(3'b010, 32'h2000, 32'h11223344, 5'd20);
        load(3'b000, 32'h2002);
        chk("fwd_lb_hit", 32'(sbi.fwd_hit), 1);
        chk("fwd_lb_data", sbi.fwd_data, 32'h11223344);
        chk("fwd_lb_conflict", 32'(sbi.fwd_conflict), 0);
        load(3'b010, 32'h2004);
        chk("fwd_miss", {sbi.fwd_data[29:0], sbi.fwd_hit, sbi.fwd_conflict}, 0);
        enq(3'b000, 32'h2000, 32'h00000055, 5'd21);
        load(3'b010, 32'h2000);
        chk("fwd_lw_conflict", 32'(sbi.fwd_conflict), 1);
        chk("fwd_lw_nohit", 32'(sbi.fwd_hit), 0);
        load(3'b000, 32'h2000);
        chk("fwd_youngest_data", sbi.fwd_data, 32'h00000055);
        load(3'b000, 32'h2001);
        chk("fwd_older_data", sbi.fwd_data, 32'h11223344);
        sbi.flush = 1'b1;
        step();
        sbi.flush = 1'b0;
        chk("fwd_flush_empty", 32'(sbi.empty), 1);
        load(3'b010, 32'h2000);
        chk("fwd_after_flush", 32'(sbi.fwd_hit), 0);

        // Async reset during a stalled write
        enq(3'b010, 32'h7000, 32'hCAFEF00D, 5'd1);
        commit(5'd1);
        for (int k = 0; k < 5; k++)
            step();
        chk("stall_wvalid", 32'(sbi.mem_wvalid), 1);
        chk("stall_wdata", sbi.mem_wdata, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wvalid", 32'(sbi.mem_wvalid), 0);
        chk("arst_waddr", sbi.mem_waddr, 0);
        chk("arst_wdata", sbi.mem_wdata, 0);
        chk("arst_wstrb", 32'(sbi.mem_wstrb), 0);
        chk("arst_empty", 32'(sbi.empty), 1);
        chk("arst_enq_ready", 32'(sbi.enq_ready), 1);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_write_dropped", 32'(sbi.mem_wvalid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
